// File: rtl/load_store_queue.sv
// In-order load/store queue: snoops result buses for operands, issues one memory access at a time.
// Optional LSQ_SPEC_LOAD_EN lets non-IO loads go to memory before they commit.
module load_store_queue #(
  parameter int LSQ_DEPTH = 16,
  parameter int ROB_IDX_W = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          roll_back,
  input  logic                          disp_valid,
  input  logic                          disp_is_store,
  input  logic [2:0]                    disp_op,
  input  logic [31:0]                   disp_vj,
  input  logic [31:0]                   disp_vk,
  input  logic                          disp_qj_en,
  input  logic                          disp_qk_en,
  input  logic [ROB_IDX_W-1:0]          disp_qj,
  input  logic [ROB_IDX_W-1:0]          disp_qk,
  input  logic [31:0]                   disp_imm,
  input  logic [ROB_IDX_W-1:0]          disp_rob_idx,
  output logic                          lsq_full,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_rob_idx,
  input  logic [CDB_PORTS*32-1:0]       cdb_val,
  input  logic                          commit_valid,
  input  logic [ROB_IDX_W-1:0]          commit_rob_idx,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [1:0]                    mem_req_size,
  output logic [31:0]                   mem_req_addr,
  output logic [31:0]                   mem_req_wdata,
  input  logic                          mem_resp_valid,
  input  logic [31:0]                   mem_resp_rdata,
  input  logic                          mem_wr_done,
  output logic                          res_valid,
  output logic [ROB_IDX_W-1:0]          res_rob_idx,
  output logic [31:0]                   res_val
);
  localparam int PTR_W = $clog2(LSQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_B  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_HU = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;

  logic                 valid_q     [LSQ_DEPTH];
  logic                 valid_d     [LSQ_DEPTH];
  logic                 committed_q [LSQ_DEPTH];
  logic                 committed_d [LSQ_DEPTH];
  logic                 is_store_q  [LSQ_DEPTH];
  logic                 is_store_d  [LSQ_DEPTH];
  logic [2:0]           op_q        [LSQ_DEPTH];
  logic [2:0]           op_d        [LSQ_DEPTH];
  logic [31:0]          vj_q        [LSQ_DEPTH];
  logic [31:0]          vj_d        [LSQ_DEPTH];
  logic [31:0]          vk_q        [LSQ_DEPTH];
  logic [31:0]          vk_d        [LSQ_DEPTH];
  logic                 qj_en_q     [LSQ_DEPTH];
  logic                 qj_en_d     [LSQ_DEPTH];
  logic                 qk_en_q     [LSQ_DEPTH];
  logic                 qk_en_d     [LSQ_DEPTH];
  logic [ROB_IDX_W-1:0] qj_q        [LSQ_DEPTH];
  logic [ROB_IDX_W-1:0] qj_d        [LSQ_DEPTH];
  logic [ROB_IDX_W-1:0] qk_q        [LSQ_DEPTH];
  logic [ROB_IDX_W-1:0] qk_d        [LSQ_DEPTH];
  logic [31:0]          imm_q       [LSQ_DEPTH];
  logic [31:0]          imm_d       [LSQ_DEPTH];
  logic [ROB_IDX_W-1:0] rob_q       [LSQ_DEPTH];
  logic [ROB_IDX_W-1:0] rob_d       [LSQ_DEPTH];

  logic                 mem_req_valid_q, mem_req_valid_d, mem_req_we_q, mem_req_we_d;
  logic [1:0]           mem_req_size_q, mem_req_size_d;
  logic [31:0]          mem_req_addr_q, mem_req_addr_d, mem_req_wdata_q, mem_req_wdata_d;
  logic                 inf_load_q, inf_load_d, inf_committed_q, inf_committed_d;
  logic                 squash_q, squash_d;
  logic [2:0]           inf_op_q, inf_op_d;
  logic [ROB_IDX_W-1:0] inf_rob_q, inf_rob_d;
  logic                 res_valid_q, res_valid_d;
  logic [ROB_IDX_W-1:0] res_rob_q, res_rob_d;
  logic [31:0]          res_val_q, res_val_d;

  logic             push, pop, head_ready, head_may_issue, commit_inf, inf_safe, kill_inf;
  logic [31:0]      head_addr;
  logic [32:0]      hit_j, hit_k, dhit_j, dhit_k;
  logic [CNT_W-1:0] keep;
  logic [PTR_W-1:0] scan_idx;
`ifdef LSQ_SPEC_LOAD_EN
  logic             head_io;
`endif

  // Returns {hit, value}; later assignments win, so the lowest CDB port beats the own result bus.
  function automatic logic [32:0] snoop(input logic [ROB_IDX_W-1:0] tag,
                                        input logic [CDB_PORTS-1:0] cv,
                                        input logic [CDB_PORTS*ROB_IDX_W-1:0] ct,
                                        input logic [CDB_PORTS*32-1:0] cval,
                                        input logic rv, input logic [ROB_IDX_W-1:0] rt,
                                        input logic [31:0] rval);
    logic [32:0] r;
    r = '0;
    if (rv && rt == tag) r = {1'b1, rval};
    for (int p = CDB_PORTS - 1; p >= 0; p--)
      if (cv[p] && ct[p*ROB_IDX_W +: ROB_IDX_W] == tag) r = {1'b1, cval[p*32 +: 32]};
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      OP_B:    return {{24{d[7]}}, d[7:0]};
      OP_H:    return {{16{d[15]}}, d[15:0]};
      OP_BU:   return {24'b0, d[7:0]};
      OP_HU:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: return 2'd1;
      OP_H, OP_HU: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  assign lsq_full = (count_q > CNT_W'(LSQ_DEPTH - 2));

  always_comb begin
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;  state_d = state_q;
    for (int i = 0; i < LSQ_DEPTH; i++) begin
      valid_d[i] = valid_q[i];  committed_d[i] = committed_q[i];  is_store_d[i] = is_store_q[i];
      op_d[i] = op_q[i];  vj_d[i] = vj_q[i];  vk_d[i] = vk_q[i];  qj_en_d[i] = qj_en_q[i];
      qk_en_d[i] = qk_en_q[i];  qj_d[i] = qj_q[i];  qk_d[i] = qk_q[i];  imm_d[i] = imm_q[i];
      rob_d[i] = rob_q[i];
    end
    mem_req_valid_d = mem_req_valid_q;  mem_req_we_d = mem_req_we_q;
    mem_req_size_d = mem_req_size_q;  mem_req_addr_d = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    inf_load_d = inf_load_q;  inf_op_d = inf_op_q;  inf_rob_d = inf_rob_q;
    inf_committed_d = inf_committed_q;  squash_d = squash_q;
    res_valid_d = 1'b0;  res_rob_d = res_rob_q;  res_val_d = res_val_q;
    pop = 1'b0;  hit_j = '0;  hit_k = '0;  dhit_j = '0;  dhit_k = '0;  keep = '0;  scan_idx = '0;

    head_addr  = vj_q[head_q] + imm_q[head_q];
    head_ready = valid_q[head_q] && !qj_en_q[head_q] && (!is_store_q[head_q] || !qk_en_q[head_q]);
`ifdef LSQ_SPEC_LOAD_EN
    head_io        = (head_addr[17:16] == 2'b11);
    head_may_issue = committed_q[head_q] || (!is_store_q[head_q] && !head_io);
`else
    head_may_issue = committed_q[head_q];
`endif
    commit_inf = commit_valid && (commit_rob_idx == inf_rob_q);
    inf_safe   = inf_committed_q || commit_inf;
    kill_inf   = squash_q || (roll_back && !inf_safe);
    push       = disp_valid && !lsq_full && !roll_back;

    for (int i = 0; i < LSQ_DEPTH; i++) begin
      if (valid_q[i]) begin
        hit_j = snoop(qj_q[i], cdb_valid, cdb_rob_idx, cdb_val, res_valid_q, res_rob_q, res_val_q);
        hit_k = snoop(qk_q[i], cdb_valid, cdb_rob_idx, cdb_val, res_valid_q, res_rob_q, res_val_q);
        if (qj_en_q[i] && hit_j[32]) begin qj_en_d[i] = 1'b0; vj_d[i] = hit_j[31:0]; end
        if (qk_en_q[i] && hit_k[32]) begin qk_en_d[i] = 1'b0; vk_d[i] = hit_k[31:0]; end
        if (commit_valid && commit_rob_idx == rob_q[i]) committed_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (head_ready && head_may_issue && !roll_back) begin
        state_d         = S_REQ;
        mem_req_valid_d = 1'b1;
        mem_req_we_d    = is_store_q[head_q];
        mem_req_size_d  = size_of(op_q[head_q]);
        mem_req_addr_d  = head_addr;
        mem_req_wdata_d = vk_q[head_q];
        inf_load_d      = !is_store_q[head_q];
        inf_op_d        = op_q[head_q];
        inf_rob_d       = rob_q[head_q];
        inf_committed_d = committed_d[head_q];
        squash_d        = 1'b0;
      end
      S_REQ: if (mem_req_ready) begin
        mem_req_valid_d = 1'b0;
        state_d         = S_WAIT;
        pop             = !kill_inf;
      end
      S_WAIT: if (inf_load_q ? mem_resp_valid : mem_wr_done) begin
        state_d = S_IDLE;
        if (inf_load_q && !kill_inf) begin
          res_valid_d = 1'b1;
          res_rob_d   = inf_rob_q;
          res_val_d   = extend(inf_op_q, mem_resp_rdata);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) begin
      if (commit_inf) inf_committed_d = 1'b1;
      if (roll_back && !inf_safe) squash_d = 1'b1;
    end

    // Committed entries form a prefix from head, so the survivors end at the youngest committed one.
    if (roll_back) begin
      for (int k = 0; k < LSQ_DEPTH; k++) begin
        scan_idx = head_q + PTR_W'(k);
        if (valid_q[scan_idx] && committed_d[scan_idx]) keep = CNT_W'(k + 1);
      end
      for (int i = 0; i < LSQ_DEPTH; i++)
        if (!committed_d[i]) valid_d[i] = 1'b0;
      tail_d  = head_q + keep[PTR_W-1:0];
      count_d = keep - CNT_W'(pop);
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    if (push) begin
      dhit_j = snoop(disp_qj, cdb_valid, cdb_rob_idx, cdb_val, res_valid_q, res_rob_q, res_val_q);
      dhit_k = snoop(disp_qk, cdb_valid, cdb_rob_idx, cdb_val, res_valid_q, res_rob_q, res_val_q);
      valid_d[tail_q]     = 1'b1;
      committed_d[tail_q] = 1'b0;
      is_store_d[tail_q]  = disp_is_store;
      op_d[tail_q]        = disp_op;
      imm_d[tail_q]       = disp_imm;
      rob_d[tail_q]       = disp_rob_idx;
      qj_d[tail_q]        = disp_qj;
      qk_d[tail_q]        = disp_qk;
      qj_en_d[tail_q]     = disp_qj_en && !dhit_j[32];
      qk_en_d[tail_q]     = disp_qk_en && !dhit_k[32];
      vj_d[tail_q]        = (disp_qj_en && dhit_j[32]) ? dhit_j[31:0] : disp_vj;
      vk_d[tail_q]        = (disp_qk_en && dhit_k[32]) ? dhit_k[31:0] : disp_vk;
      tail_d              = tail_q + PTR_W'(1);
    end

    if (pop) begin
      valid_d[head_q]     = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      head_q <= '0;  tail_q <= '0;  count_q <= '0;  state_q <= S_IDLE;
      for (int i = 0; i < LSQ_DEPTH; i++) begin valid_q[i] <= 1'b0; committed_q[i] <= 1'b0; end
      mem_req_valid_q <= 1'b0;  mem_req_we_q <= 1'b0;  mem_req_size_q <= '0;
      mem_req_addr_q <= '0;  mem_req_wdata_q <= '0;
      inf_load_q <= 1'b0;  inf_op_q <= '0;  inf_rob_q <= '0;  inf_committed_q <= 1'b0;
      squash_q <= 1'b0;
      res_valid_q <= 1'b0;  res_rob_q <= '0;  res_val_q <= '0;
    end else if (rdy_in) begin
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;  state_q <= state_d;
      for (int i = 0; i < LSQ_DEPTH; i++) begin valid_q[i] <= valid_d[i]; committed_q[i] <= committed_d[i]; end
      mem_req_valid_q <= mem_req_valid_d;  mem_req_we_q <= mem_req_we_d;
      mem_req_size_q <= mem_req_size_d;  mem_req_addr_q <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      inf_load_q <= inf_load_d;  inf_op_q <= inf_op_d;  inf_rob_q <= inf_rob_d;
      inf_committed_q <= inf_committed_d;  squash_q <= squash_d;
      res_valid_q <= res_valid_d;  res_rob_q <= res_rob_d;  res_val_q <= res_val_d;
    end
  end

  // Payload fields need no reset: valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (rdy_in) begin
      for (int i = 0; i < LSQ_DEPTH; i++) begin
        is_store_q[i] <= is_store_d[i];  op_q[i] <= op_d[i];  vj_q[i] <= vj_d[i];  vk_q[i] <= vk_d[i];
        qj_en_q[i] <= qj_en_d[i];  qk_en_q[i] <= qk_en_d[i];  qj_q[i] <= qj_d[i];  qk_q[i] <= qk_d[i];
        imm_q[i] <= imm_d[i];  rob_q[i] <= rob_d[i];
      end
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_size  = mem_req_size_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign res_valid     = res_valid_q;
  assign res_rob_idx   = res_rob_q;
  assign res_val       = res_val_q;
endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: table-driven load vectors plus hand-written store/flush/reset sequences,
// with memory requests and load results checked against scoreboard queues.
module tb_load_store_queue;
  localparam int D = 16;
  localparam int RW = 4;
  localparam int CP = 2;

  logic clk = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, roll_back = 1'b0;
  logic disp_valid = 1'b0, disp_is_store = 1'b0, disp_qj_en = 1'b0, disp_qk_en = 1'b0;
  logic [2:0] disp_op = '0;
  logic [31:0] disp_vj = '0, disp_vk = '0, disp_imm = '0;
  logic [RW-1:0] disp_qj = '0, disp_qk = '0, disp_rob_idx = '0;
  logic lsq_full;
  logic [CP-1:0] cdb_valid = '0;
  logic [CP*RW-1:0] cdb_rob_idx = '0;
  logic [CP*32-1:0] cdb_val = '0;
  logic commit_valid = 1'b0;
  logic [RW-1:0] commit_rob_idx = '0;
  logic mem_req_valid, mem_req_we;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_wr_done = 1'b0;
  logic [1:0] mem_req_size;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = '0;
  logic res_valid;
  logic [RW-1:0] res_rob_idx;
  logic [31:0] res_val;

  load_store_queue #(.LSQ_DEPTH(D), .ROB_IDX_W(RW), .CDB_PORTS(CP)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj_en(disp_qj_en), .disp_qk_en(disp_qk_en),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
    .lsq_full(lsq_full), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_size(mem_req_size), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_wr_done(mem_wr_done),
    .res_valid(res_valid), .res_rob_idx(res_rob_idx), .res_val(res_val));

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct packed { logic [RW-1:0] rob; logic [31:0] val; } res_t;
  typedef struct { logic [2:0] op; logic [RW-1:0] rob; logic [31:0] vj, imm, rdata, addr;
                   logic [1:0] size; logic [31:0] val; } vec_t;

  req_t req_q[$];
  res_t res_q[$];
  vec_t vecs[9];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: compare each accepted request and each result against the oldest expectation.
  always @(negedge clk) begin
    req_t er;
    res_t es;
    if (!rst_in) begin
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) checkOutput("unexpected_req", 32'd1, 32'd0);
        else begin
          er = req_q.pop_front();
          checkOutput("req_we", {31'b0, mem_req_we}, {31'b0, er.we});
          checkOutput("req_size", {30'b0, mem_req_size}, {30'b0, er.size});
          checkOutput("req_addr", mem_req_addr, er.addr);
          if (er.we) checkOutput("req_wdata", mem_req_wdata, er.wdata);
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) checkOutput("unexpected_res", 32'd1, 32'd0);
        else begin
          es = res_q.pop_front();
          checkOutput("res_rob", {28'b0, res_rob_idx}, {28'b0, es.rob});
          checkOutput("res_val", res_val, es.val);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] op, input logic [31:0] vj,
                               input logic [31:0] vk, input logic qj_en, input logic [RW-1:0] qj,
                               input logic [31:0] imm, input logic [RW-1:0] rob);
    disp_valid = 1'b1; disp_is_store = st; disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj_en = qj_en; disp_qj = qj; disp_qk_en = 1'b0; disp_qk = '0; disp_imm = imm;
    disp_rob_idx = rob;
    tick(1);
    disp_valid = 1'b0;
  endtask

  task automatic commitRob(input logic [RW-1:0] rob);
    commit_valid = 1'b1; commit_rob_idx = rob;
    tick(1);
    commit_valid = 1'b0;
  endtask

  task automatic waitReq(output logic ok);
    int n = 0;
    while (!mem_req_valid && n < 50) begin tick(1); n++; end
    ok = mem_req_valid;
    if (!ok) checkOutput("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic completeReq(input logic is_load, input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    if (is_load) begin mem_resp_valid = 1'b1; mem_resp_rdata = rdata; end
    else mem_wr_done = 1'b1;
    tick(1);
    mem_resp_valid = 1'b0; mem_wr_done = 1'b0;
    tick(1);
  endtask

  task automatic serveReq(input logic is_load, input logic [31:0] rdata);
    logic ok;
    waitReq(ok);
    if (ok) completeReq(is_load, rdata);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    // op, rob, vj, imm, rdata, addr, size, val  (op: 0=B 1=H 2=W 4=BU 5=HU)
    vecs[0] = '{3'd2, 4'd3, 32'h100,      32'h4,        32'hFFFFFF80, 32'h104, 2'd3, 32'hFFFFFF80};
    vecs[1] = '{3'd0, 4'd4, 32'h200,      32'h1,        32'h00000080, 32'h201, 2'd1, 32'hFFFFFF80};
    vecs[2] = '{3'd4, 4'd5, 32'h200,      32'h2,        32'h00000080, 32'h202, 2'd1, 32'h00000080};
    vecs[3] = '{3'd1, 4'd6, 32'h300,      32'h0,        32'h00008001, 32'h300, 2'd2, 32'hFFFF8001};
    vecs[4] = '{3'd5, 4'd7, 32'h300,      32'h2,        32'h00008001, 32'h302, 2'd2, 32'h00008001};
    vecs[5] = '{3'd0, 4'd8, 32'h400,      32'h0,        32'h1234567F, 32'h400, 2'd1, 32'h0000007F};
    vecs[6] = '{3'd1, 4'd9, 32'h400,      32'h2,        32'h12347FFF, 32'h402, 2'd2, 32'h00007FFF};
    vecs[7] = '{3'd2, 4'd1, 32'hFFFFFFFC, 32'h8,        32'hDEADBEEF, 32'h4,   2'd3, 32'hDEADBEEF};
    vecs[8] = '{3'd2, 4'd2, 32'h1000,     32'hFFFFFFF0, 32'h0BADF00D, 32'hFF0, 2'd3, 32'h0BADF00D};

    tick(3);
    rst_in = 1'b0;
    tick(1);
    checkOutput("rst_lsq_full", {31'b0, lsq_full}, 32'd0);
    checkOutput("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("rst_req_we", {31'b0, mem_req_we}, 32'd0);
    checkOutput("rst_req_size", {30'b0, mem_req_size}, 32'd0);
    checkOutput("rst_req_addr", mem_req_addr, 32'd0);
    checkOutput("rst_req_wdata", mem_req_wdata, 32'd0);
    checkOutput("rst_res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("rst_res_rob", {28'b0, res_rob_idx}, 32'd0);
    checkOutput("rst_res_val", res_val, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].op, vecs[i].vj, 32'h0, 1'b0, 4'd0, vecs[i].imm, vecs[i].rob);
      req_q.push_back('{1'b0, vecs[i].size, vecs[i].addr, 32'h0});
      res_q.push_back('{vecs[i].rob, vecs[i].val});
      commitRob(vecs[i].rob);
      serveReq(1'b1, vecs[i].rdata);
    end

    // Uncommitted store stays put; after commit the request must hold while ready is low.
    applyStimulus(1'b1, 3'd2, 32'h800, 32'hCAFEBABE, 1'b0, 4'd0, 32'h20, 4'd5);
    tick(6);
    checkOutput("store_uncommitted_noreq", {31'b0, mem_req_valid}, 32'd0);
    commitRob(4'd5);
    req_q.push_back('{1'b1, 2'd3, 32'h820, 32'hCAFEBABE});
    waitReq(ok);
    tick(3);
    checkOutput("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
    checkOutput("req_hold_addr", mem_req_addr, 32'h820);
    checkOutput("req_hold_wdata", mem_req_wdata, 32'hCAFEBABE);
    if (ok) completeReq(1'b0, 32'h0);

    // Same-cycle CDB capture on dispatch, port 1.
    cdb_valid = 2'b10; cdb_rob_idx = {4'd7, 4'd0}; cdb_val = {32'h200, 32'h0};
    applyStimulus(1'b0, 3'd2, 32'hBAD, 32'h0, 1'b1, 4'd7, 32'h10, 4'd11);
    cdb_valid = '0;
    req_q.push_back('{1'b0, 2'd3, 32'h210, 32'h0});
    res_q.push_back('{4'd11, 32'h55AA55AA});
    commitRob(4'd11);
    serveReq(1'b1, 32'h55AA55AA);

    // Waiting entry woken by both ports with the same tag: port 0 must win.
    applyStimulus(1'b0, 3'd2, 32'hBAD, 32'h0, 1'b1, 4'd2, 32'h8, 4'd10);
    cdb_valid = 2'b11; cdb_rob_idx = {4'd2, 4'd2}; cdb_val = {32'h999, 32'h400};
    tick(1);
    cdb_valid = '0;
    req_q.push_back('{1'b0, 2'd3, 32'h408, 32'h0});
    res_q.push_back('{4'd10, 32'h00000001});
    commitRob(4'd10);
    serveReq(1'b1, 32'h00000001);

    // IO load waits for commit whatever the speculation setting.
    applyStimulus(1'b0, 3'd2, 32'h30000, 32'h0, 1'b0, 4'd0, 32'h0, 4'd9);
    tick(6);
    checkOutput("io_load_noreq", {31'b0, mem_req_valid}, 32'd0);
    commitRob(4'd9);
    req_q.push_back('{1'b0, 2'd3, 32'h30000, 32'h0});
    res_q.push_back('{4'd9, 32'h11223344});
    serveReq(1'b1, 32'h11223344);

    // Frozen while rdy_in is low: dispatch has no effect.
    rdy_in = 1'b0;
    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 1'b0, 4'd1, 32'h0, 4'd1);
    checkOutput("freeze_count", 32'(dut.count_q), 32'd0);
    rdy_in = 1'b1;

    // Fill to 15, commit the two oldest stores, flush the rest.
    for (int i = 0; i < 15; i++) begin
      if (i == 14) checkOutput("full_at_14", {31'b0, lsq_full}, 32'd0);
      if (i < 2) applyStimulus(1'b1, 3'd2, 32'h2000, 32'hA0 + i, 1'b0, 4'd0, 32'(i * 4), RW'(i));
      else       applyStimulus(1'b0, 3'd2, 32'h3000, 32'h0, 1'b0, 4'd0, 32'(i * 4), RW'(i));
    end
    checkOutput("full_at_15", {31'b0, lsq_full}, 32'd1);
    checkOutput("count_15", 32'(dut.count_q), 32'd15);
    req_q.push_back('{1'b1, 2'd3, 32'h2000, 32'hA0});
    req_q.push_back('{1'b1, 2'd3, 32'h2004, 32'hA1});
    commitRob(4'd0);
    commitRob(4'd1);
    tick(2);
    roll_back = 1'b1;
    tick(1);
    roll_back = 1'b0;
    checkOutput("rollback_count", 32'(dut.count_q), 32'd2);
    checkOutput("rollback_full", {31'b0, lsq_full}, 32'd0);
    serveReq(1'b0, 32'h0);
    serveReq(1'b0, 32'h0);
    tick(5);
    checkOutput("drained_count", 32'(dut.count_q), 32'd0);
    checkOutput("drained_noreq", {31'b0, mem_req_valid}, 32'd0);

    // Reset with a load in flight: its late response must be dropped.
    applyStimulus(1'b0, 3'd2, 32'h500, 32'h0, 1'b0, 4'd0, 32'h0, 4'd6);
    commitRob(4'd6);
    req_q.push_back('{1'b0, 2'd3, 32'h500, 32'h0});
    waitReq(ok);
    mem_req_ready = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    tick(1);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h77777777;
    tick(1);
    mem_resp_valid = 1'b0;
    tick(1);
    checkOutput("abandon_res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("abandon_count", 32'(dut.count_q), 32'd0);

    tick(3);
    checkOutput("req_queue_empty", 32'(req_q.size()), 32'd0);
    checkOutput("res_queue_empty", 32'(res_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
